// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA raster timing, framebuffer read addressing with
// integer pixel scaling, read-latency compensation and gray/RGB332 output.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   mode         pixel format, 0 = 8-bit gray, 1 = RGB332 (latched per frame)
//   border_rgb   {r,g,b} colour for active pixels outside the image
//   fb_ren       framebuffer read enable (image region, combinational)
//   fb_addr      framebuffer read address
//   fb_rdata     framebuffer data, valid MEM_LAT clocks after fb_ren
//   h_sync       horizontal sync, active level H_POL
//   v_sync       vertical sync, active level V_POL
//   sync_b       composite sync, tied low
//   blank_b      1 = active video
//   red/green/blue  pixel colour
//   x, y         coordinates of the pixel on red/green/blue
//   frame_start  one-clock pulse with pixel (0,0)

module vga_frame_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int SCALE    = 2,
    parameter int MEM_LAT  = 1,
    parameter int AW       = 17,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic [23:0]   border_rgb,
    output logic          fb_ren,
    output logic [AW-1:0] fb_addr,
    input  logic [7:0]    fb_rdata,
    output logic          h_sync,
    output logic          v_sync,
    output logic          sync_b,
    output logic          blank_b,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);
    localparam int SW    = $clog2(SCALE + 1);

    // Image extent clipped to the visible area.
    localparam int IMG_XE = (IMG_W * SCALE < H_ACTIVE) ? IMG_W * SCALE : H_ACTIVE;
    localparam int IMG_YE = (IMG_H * SCALE < V_ACTIVE) ? IMG_H * SCALE : V_ACTIVE;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_IMG_E  = HW'(IMG_XE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_IMG_E  = VW'(IMG_YE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

    localparam int T = MEM_LAT - 1;

    // Raster and address-generation state
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic [SW-1:0] hsc;
    logic [SW-1:0] vsc;
    logic [AW-1:0] col;
    logic [AW-1:0] row_base;
    logic [AW-1:0] addr_hold;
    logic          mode_q;

    logic h_end;
    logic v_end;
    logic active_now;
    logic img_now;
    logic hsync_now;
    logic vsync_now;
    logic fs_now;
    logic mode_now;

    assign h_end      = (hc == H_LAST);
    assign v_end      = (vc == V_LAST);
    assign active_now = (hc < H_ACT_E) && (vc < V_ACT_E);
    assign img_now    = (hc < H_IMG_E) && (vc < V_IMG_E);
    assign hsync_now  = (hc >= H_SYNC_S && hc < H_SYNC_E) ? H_POL : ~H_POL;
    assign vsync_now  = (vc >= V_SYNC_S && vc < V_SYNC_E) ? V_POL : ~V_POL;
    assign fs_now     = (hc == '0) && (vc == '0);

    // Pixel (0,0) already uses the freshly sampled mode, so the whole
    // frame carries one format through the pipeline.
    assign mode_now   = fs_now ? mode : mode_q;

    assign fb_ren  = img_now & ~reset;
    assign fb_addr = fb_ren ? (row_base + col) : addr_hold;
    assign sync_b  = 1'b0;

    // Counters: hsc/vsc count output pixels per source pixel, col and
    // row_base step the source address without any multiply or divide.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc        <= '0;
            vc        <= '0;
            hsc       <= '0;
            vsc       <= '0;
            col       <= '0;
            row_base  <= '0;
            addr_hold <= '0;
            mode_q    <= 1'b0;
        end else begin
            addr_hold <= fb_addr;
            if (fs_now) begin
                mode_q <= mode;
            end
            if (h_end) begin
                hc  <= '0;
                hsc <= '0;
                col <= '0;
                if (v_end) begin
                    vc       <= '0;
                    vsc      <= '0;
                    row_base <= '0;
                end else begin
                    vc <= vc + 1'b1;
                    if (vsc == S_LAST) begin
                        vsc      <= '0;
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        vsc <= vsc + 1'b1;
                    end
                end
            end else begin
                hc <= hc + 1'b1;
                if (hsc == S_LAST) begin
                    hsc <= '0;
                    col <= col + 1'b1;
                end else begin
                    hsc <= hsc + 1'b1;
                end
            end
        end
    end

    // Control delay line covering the framebuffer read latency
    logic [MEM_LAT-1:0] hs_p;
    logic [MEM_LAT-1:0] vs_p;
    logic [MEM_LAT-1:0] act_p;
    logic [MEM_LAT-1:0] img_p;
    logic [MEM_LAT-1:0] fs_p;
    logic [MEM_LAT-1:0] mode_p;
    logic [CW-1:0]      x_p [MEM_LAT];
    logic [CW-1:0]      y_p [MEM_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_p   <= {MEM_LAT{~H_POL}};
            vs_p   <= {MEM_LAT{~V_POL}};
            act_p  <= '0;
            img_p  <= '0;
            fs_p   <= '0;
            mode_p <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                x_p[i] <= '0;
                y_p[i] <= '0;
            end
        end else begin
            hs_p[0]   <= hsync_now;
            vs_p[0]   <= vsync_now;
            act_p[0]  <= active_now;
            img_p[0]  <= img_now;
            fs_p[0]   <= fs_now;
            mode_p[0] <= mode_now;
            x_p[0]    <= CW'(hc);
            y_p[0]    <= CW'(vc);
            for (int i = 1; i < MEM_LAT; i++) begin
                hs_p[i]   <= hs_p[i-1];
                vs_p[i]   <= vs_p[i-1];
                act_p[i]  <= act_p[i-1];
                img_p[i]  <= img_p[i-1];
                fs_p[i]   <= fs_p[i-1];
                mode_p[i] <= mode_p[i-1];
                x_p[i]    <= x_p[i-1];
                y_p[i]    <= y_p[i-1];
            end
        end
    end

    // Colour select at the output stage
    logic [23:0] rgb_next;

    always_comb begin
        rgb_next = '0;
        if (act_p[T]) begin
            if (img_p[T]) begin
                if (mode_p[T]) begin
                    rgb_next = {fb_rdata[7:5], fb_rdata[7:5], fb_rdata[7:6],
                                fb_rdata[4:2], fb_rdata[4:2], fb_rdata[4:3],
                                {4{fb_rdata[1:0]}}};
                end else begin
                    rgb_next = {fb_rdata, fb_rdata, fb_rdata};
                end
            end else begin
                rgb_next = border_rgb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            blank_b     <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= hs_p[T];
            v_sync      <= vs_p[T];
            blank_b     <= act_p[T];
            red         <= rgb_next[23:16];
            green       <= rgb_next[15:8];
            blue        <= rgb_next[7:0];
            x           <= x_p[T];
            y           <= y_p[T];
            frame_start <= fs_p[T];
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: directed bench for vga_frame_scanner on a tiny
// 8x4 raster (H_TOT=14, V_TOT=7) with a 3x2 image scaled by 2.

module tb_vga_frame_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        ram_e3 = 1'b0;
    logic [23:0] border_rgb = 24'hFF0000;
    logic        fb_ren;
    logic [16:0] fb_addr;
    logic [7:0]  fb_rdata;
    logic        h_sync;
    logic        v_sync;
    logic        sync_b;
    logic        blank_b;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        frame_start;

    int n_chk = 0;
    int n_fail = 0;
    int k = 0;

    always #5 clk = ~clk;

    // One-clock-latency RAM: data = addr + 8'h10, or 8'hE3 when forced
    always_ff @(posedge clk) begin
        fb_rdata <= ram_e3 ? 8'hE3 : fb_addr[7:0] + 8'h10;
    end

    vga_frame_scanner #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0),
        .IMG_W(3), .IMG_H(2), .SCALE(2), .MEM_LAT(1),
        .AW(17), .CW(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .border_rgb(border_rgb),
        .fb_ren(fb_ren),
        .fb_addr(fb_addr),
        .fb_rdata(fb_rdata),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .sync_b(sync_b),
        .blank_b(blank_b),
        .red(red),
        .green(green),
        .blue(blue),
        .x(x),
        .y(y),
        .frame_start(frame_start)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        k += n;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        k = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({h_sync, v_sync, blank_b, sync_b, frame_start} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 11000",
                     {h_sync, v_sync, blank_b, sync_b, frame_start});
        end
        n_chk++;
        if ({red, green, blue} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_rgb: got %h want 000000", {red, green, blue});
        end
        n_chk++;
        if ({x, y} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", x, y);
        end
        n_chk++;
        if ({fb_ren, fb_addr} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_fb: got ren=%b addr=%0d want 0 0", fb_ren, fb_addr);
        end
        reset = 1'b0;
        #1;
        k = 0;
        n_chk++;
        if (fb_ren !== 1'b1 || fb_addr !== 17'd0) begin
            n_fail++;
            $display("FAIL release_fb: got ren=%b addr=%0d want 1 0", fb_ren, fb_addr);
        end
        step(1);
        n_chk++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL fs_early: got %b want 0", frame_start);
        end
        step(1);
        n_chk++;
        if (frame_start !== 1'b1 || blank_b !== 1'b1 || {red, green, blue} !== 24'h101010) begin
            n_fail++;
            $display("FAIL first_pixel: got fs=%b blank=%b rgb=%h want 1 1 101010",
                     frame_start, blank_b, {red, green, blue});
        end
    endtask

    task automatic test_addr();
        int hcv;
        int vcv;
        logic        exp_ren;
        logic [16:0] exp_addr;
        do_reset();
        for (int i = 0; i <= 56; i++) begin
            hcv = i % 14;
            vcv = i / 14;
            if (vcv >= 4) begin
                exp_ren  = 1'b0;
                exp_addr = 17'd5;
            end else if (hcv < 6) begin
                exp_ren  = 1'b1;
                exp_addr = 17'((vcv >= 2 ? 3 : 0) + hcv / 2);
            end else begin
                exp_ren  = 1'b0;
                exp_addr = 17'((vcv >= 2 ? 3 : 0) + 2);
            end
            n_chk++;
            if (fb_ren !== exp_ren || fb_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL addr hc=%0d vc=%0d: got ren=%b addr=%0d want %b %0d",
                         hcv, vcv, fb_ren, fb_addr, exp_ren, exp_addr);
            end
            step(1);
        end
    endtask

    task automatic test_output();
        border_rgb = 24'hFF0000;
        do_reset();
        step(4);
        n_chk++;
        if ({red, green, blue} !== 24'h111111 || x !== 10'd2 || y !== 10'd0 || blank_b !== 1'b1) begin
            n_fail++;
            $display("FAIL out_x2: got rgb=%h x=%0d y=%0d blank=%b want 111111 2 0 1",
                     {red, green, blue}, x, y, blank_b);
        end
        step(3);
        n_chk++;
        if ({red, green, blue} !== 24'h121212 || x !== 10'd5) begin
            n_fail++;
            $display("FAIL out_x5: got rgb=%h x=%0d want 121212 5", {red, green, blue}, x);
        end
        step(1);
        n_chk++;
        if ({red, green, blue} !== 24'hFF0000 || x !== 10'd6 || blank_b !== 1'b1) begin
            n_fail++;
            $display("FAIL border_x6: got rgb=%h x=%0d blank=%b want FF0000 6 1",
                     {red, green, blue}, x, blank_b);
        end
        step(1);
        n_chk++;
        if ({red, green, blue} !== 24'hFF0000 || x !== 10'd7) begin
            n_fail++;
            $display("FAIL border_x7: got rgb=%h x=%0d want FF0000 7", {red, green, blue}, x);
        end
        step(1);
        n_chk++;
        if ({red, green, blue} !== 24'h0 || x !== 10'd8 || blank_b !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_x8: got rgb=%h x=%0d blank=%b want 000000 8 0",
                     {red, green, blue}, x, blank_b);
        end
        step(34);
        n_chk++;
        if ({red, green, blue} !== 24'h131313 || x !== 10'd0 || y !== 10'd3) begin
            n_fail++;
            $display("FAIL out_y3: got rgb=%h x=%0d y=%0d want 131313 0 3",
                     {red, green, blue}, x, y);
        end
    endtask

    task automatic test_sync();
        int h_low = 0;
        int v_low = 0;
        int b_hi = 0;
        int b_tail = 0;
        int h_bad = 0;
        int v_bad = 0;
        do_reset();
        step(2);
        for (int i = 0; i < 98; i++) begin
            if (h_sync === 1'b0) h_low++;
            if (v_sync === 1'b0) v_low++;
            if (blank_b === 1'b1) b_hi++;
            if (y >= 10'd4 && blank_b === 1'b0) b_tail++;
            if (h_sync !== ((x == 10'd10 || x == 10'd11) ? 1'b0 : 1'b1)) h_bad++;
            if (v_sync !== ((y == 10'd5) ? 1'b0 : 1'b1)) v_bad++;
            step(1);
        end
        n_chk++;
        if (h_low != 14) begin
            n_fail++;
            $display("FAIL hsync_len: got %0d low clocks want 14", h_low);
        end
        n_chk++;
        if (v_low != 14) begin
            n_fail++;
            $display("FAIL vsync_len: got %0d low clocks want 14", v_low);
        end
        n_chk++;
        if (h_bad != 0 || v_bad != 0) begin
            n_fail++;
            $display("FAIL sync_pos: got %0d/%0d misplaced want 0/0", h_bad, v_bad);
        end
        n_chk++;
        if (b_hi != 32 || b_tail != 42) begin
            n_fail++;
            $display("FAIL blank_cnt: got active=%0d vblank=%0d want 32 42", b_hi, b_tail);
        end
    endtask

    task automatic test_mode();
        mode = 1'b0;
        do_reset();
        ram_e3 = 1'b1;
        step(20);
        mode = 1'b1;
        step(10);
        n_chk++;
        if ({red, green, blue} !== 24'hE3E3E3 || y !== 10'd2) begin
            n_fail++;
            $display("FAIL mode_hold: got rgb=%h y=%0d want E3E3E3 2", {red, green, blue}, y);
        end
        step(70);
        n_chk++;
        if ({red, green, blue} !== 24'hFF00FF || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_rgb00: got rgb=%h fs=%b want FF00FF 1",
                     {red, green, blue}, frame_start);
        end
        step(17);
        n_chk++;
        if ({red, green, blue} !== 24'hFF00FF || x !== 10'd3 || y !== 10'd1) begin
            n_fail++;
            $display("FAIL mode_rgb31: got rgb=%h x=%0d y=%0d want FF00FF 3 1",
                     {red, green, blue}, x, y);
        end
        mode = 1'b0;
        ram_e3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(33);
        n_chk++;
        if (blank_b !== 1'b1 || x !== 10'd3 || y !== 10'd2 || {red, green, blue} !== 24'h141414) begin
            n_fail++;
            $display("FAIL pre_reset: got blank=%b x=%0d y=%0d rgb=%h want 1 3 2 141414",
                     blank_b, x, y, {red, green, blue});
        end
        reset = 1'b1;
        step(1);
        n_chk++;
        if ({h_sync, v_sync, blank_b, sync_b, frame_start, fb_ren} !== 6'b110000
            || fb_addr !== 17'd0 || {red, green, blue} !== 24'h0 || {x, y} !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctrl=%b addr=%0d rgb=%h x=%0d y=%0d want 110000 0 000000 0 0",
                     {h_sync, v_sync, blank_b, sync_b, frame_start, fb_ren},
                     fb_addr, {red, green, blue}, x, y);
        end
        reset = 1'b0;
        #1;
        k = 0;
        step(1);
        n_chk++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fs1: got %b want 0", frame_start);
        end
        step(1);
        n_chk++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fs2: got %b want 1", frame_start);
        end
        step(97);
        n_chk++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fs99: got %b want 0", frame_start);
        end
        step(1);
        n_chk++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_fs100: got %b want 1", frame_start);
        end
    endtask

    task automatic test_wrap();
        int last = -1;
        int first = -1;
        int pulses = 0;
        int per_bad = 0;
        int xmax = 0;
        int ymax = 0;
        do_reset();
        for (int i = 0; i <= 296; i++) begin
            if (frame_start === 1'b1) begin
                if (last >= 0 && i - last != 98) per_bad++;
                if (first < 0) first = i;
                last = i;
                pulses++;
            end
            if (int'(x) > xmax) xmax = int'(x);
            if (int'(y) > ymax) ymax = int'(y);
            step(1);
        end
        n_chk++;
        if (pulses != 4 || first != 2) begin
            n_fail++;
            $display("FAIL fs_count: got %0d pulses first at %0d want 4 at 2", pulses, first);
        end
        n_chk++;
        if (per_bad != 0) begin
            n_fail++;
            $display("FAIL fs_period: got %0d wrong periods want 0", per_bad);
        end
        n_chk++;
        if (xmax != 13 || ymax != 6) begin
            n_fail++;
            $display("FAIL xy_max: got x=%0d y=%0d want 13 6", xmax, ymax);
        end
    endtask

    initial begin
        test_reset();
        test_addr();
        test_output();
        test_sync();
        test_mode();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
